// File: rtl/adder_test_pkg.sv
// Shared types and defaults for the adder error monitor: FSM state encoding
// and default compared-word / counter widths.
package adder_test_pkg;

  localparam int DEF_WIDTH = 17;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_sat_counter.sv
// Saturating up-counter with synchronous clear. A clear wins over an increment.
// The count sticks at all-ones, so sat stays high until the next clear.
module adder_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !(&cnt_q)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = &cnt_q;

endmodule

// File: rtl/adder_error_monitor.sv
// Error-statistics monitor for an adder comparator: windowed sample/fail counts,
// sticky mismatch bits and first-failure capture. ADDER_ERRMON_HIST_EN adds per-bit histograms.
module adder_error_monitor
  import adder_test_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int MAX_SAMPLES = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     valid,
  input  logic                     error,
  input  logic [WIDTH-1:0]         bit_error,
  output logic                     busy,
  output logic                     done,
  output logic                     pass,
  output logic [CNT_W-1:0]         sample_cnt,
  output logic [CNT_W-1:0]         fail_cnt,
  output logic [WIDTH-1:0]         sticky_bits,
  output logic                     first_fail_vld,
  output logic [CNT_W-1:0]         first_fail_idx,
  output logic [WIDTH-1:0]         first_fail_bits,
  output logic                     sat
`ifdef ADDER_ERRMON_HIST_EN
  ,
  input  logic [$clog2(WIDTH)-1:0] hist_sel,
  output logic [CNT_W-1:0]         hist_cnt
`endif
);

  // Value of sample_cnt just before the accept that reaches the limit.
  localparam logic [CNT_W-1:0] LIMIT_M1 =
    (MAX_SAMPLES == 0) ? '0 : CNT_W'(MAX_SAMPLES - 1);

  state_t state_q, state_d;

  logic             accept;
  logic             clr;
  logic             limit_hit;
  logic [WIDTH-1:0] sticky_q, sticky_d;
  logic             ffv_q, ffv_d;
  logic [CNT_W-1:0] ffi_q, ffi_d;
  logic [WIDTH-1:0] ffb_q, ffb_d;
  logic             smp_sat, fail_sat, hist_sat;

  assign accept    = (state_q == ST_RUN) && valid;
  assign limit_hit = (MAX_SAMPLES != 0) && accept && (sample_cnt == LIMIT_M1);

  always_comb begin
    state_d = state_q;
    clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          clr     = 1'b1;
        end
      end
      ST_RUN: begin
        // stop has priority over a simultaneous start while running
        if (stop || limit_hit) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          clr     = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sticky_d = sticky_q;
    ffv_d    = ffv_q;
    ffi_d    = ffi_q;
    ffb_d    = ffb_q;
    if (clr) begin
      sticky_d = '0;
      ffv_d    = 1'b0;
      ffi_d    = '0;
      ffb_d    = '0;
    end else if (accept) begin
      sticky_d = sticky_q | bit_error;
      if (error && !ffv_q) begin
        ffv_d = 1'b1;
        ffi_d = sample_cnt;
        ffb_d = bit_error;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      sticky_q <= '0;
      ffv_q    <= 1'b0;
      ffi_q    <= '0;
      ffb_q    <= '0;
    end else begin
      state_q  <= state_d;
      sticky_q <= sticky_d;
      ffv_q    <= ffv_d;
      ffi_q    <= ffi_d;
      ffb_q    <= ffb_d;
    end
  end

  adder_sat_counter #(.CNT_W(CNT_W)) u_sample_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (accept),
    .cnt (sample_cnt),
    .sat (smp_sat)
  );

  adder_sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (accept && error),
    .cnt (fail_cnt),
    .sat (fail_sat)
  );

`ifdef ADDER_ERRMON_HIST_EN
  localparam int SEL_W = $clog2(WIDTH);
  localparam int NSEL  = 2 ** SEL_W;

  logic [CNT_W-1:0] hist_arr [NSEL];
  logic [NSEL-1:0]  hist_sat_arr;

  // Select codes past WIDTH map to constant-zero entries.
  for (genvar b = 0; b < NSEL; b++) begin : g_hist
    if (b < WIDTH) begin : g_cnt
      adder_sat_counter #(.CNT_W(CNT_W)) u_hist (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .inc (accept && bit_error[b]),
        .cnt (hist_arr[b]),
        .sat (hist_sat_arr[b])
      );
    end else begin : g_pad
      assign hist_arr[b]     = '0;
      assign hist_sat_arr[b] = 1'b0;
    end
  end

  assign hist_cnt = hist_arr[hist_sel];
  assign hist_sat = |hist_sat_arr;
`else
  assign hist_sat = 1'b0;
`endif

  assign busy            = (state_q == ST_RUN);
  assign done            = (state_q == ST_DONE);
  assign pass            = done && (fail_cnt == '0);
  assign sticky_bits     = sticky_q;
  assign first_fail_vld  = ffv_q;
  assign first_fail_idx  = ffi_q;
  assign first_fail_bits = ffb_q;
  assign sat             = smp_sat | fail_sat | hist_sat;

endmodule

// File: tb/tb_adder_error_monitor.sv
// Scoreboard bench for adder_error_monitor: default instance plus MAX_SAMPLES=4 and CNT_W=4 instances.
module tb_adder_error_monitor;

  typedef struct packed {
    logic        pass;
    logic [15:0] scnt;
    logic [15:0] fcnt;
    logic [16:0] sticky;
    logic        ffv;
    logic [15:0] ffi;
    logic [16:0] ffb;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, stop = 1'b0, valid = 1'b0, error = 1'b0;
  logic [16:0] bit_error = '0;

  logic m_busy, m_done, m_pass, m_ffv, m_sat;
  logic [15:0] m_scnt, m_fcnt, m_ffi;
  logic [16:0] m_sticky, m_ffb;
  logic l_busy, l_done, l_pass, l_ffv, l_sat;
  logic [15:0] l_scnt, l_fcnt, l_ffi;
  logic [16:0] l_sticky, l_ffb;
  logic s_busy, s_done, s_pass, s_ffv, s_sat;
  logic [3:0] s_scnt, s_fcnt, s_ffi;
  logic [16:0] s_sticky, s_ffb;
`ifdef ADDER_ERRMON_HIST_EN
  logic [4:0]  hist_sel = '0;
  logic [15:0] m_hist, l_hist;
  logic [3:0]  s_hist;
`endif

  int checks = 0;
  int errors = 0;
  res_t sb[$];
  res_t exp_r, act_r;

  logic        mdl_run;
  logic [15:0] mdl_cnt, mdl_fail, mdl_ffi;
  logic [16:0] mdl_sticky, mdl_ffb;
  logic        mdl_ffv;

  always #5 clk = ~clk;

  adder_error_monitor u_dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .valid(valid), .error(error),
    .bit_error(bit_error), .busy(m_busy), .done(m_done), .pass(m_pass),
    .sample_cnt(m_scnt), .fail_cnt(m_fcnt), .sticky_bits(m_sticky),
    .first_fail_vld(m_ffv), .first_fail_idx(m_ffi), .first_fail_bits(m_ffb), .sat(m_sat)
`ifdef ADDER_ERRMON_HIST_EN
    , .hist_sel(hist_sel), .hist_cnt(m_hist)
`endif
  );

  adder_error_monitor #(.MAX_SAMPLES(4)) u_lim (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .valid(valid), .error(error),
    .bit_error(bit_error), .busy(l_busy), .done(l_done), .pass(l_pass),
    .sample_cnt(l_scnt), .fail_cnt(l_fcnt), .sticky_bits(l_sticky),
    .first_fail_vld(l_ffv), .first_fail_idx(l_ffi), .first_fail_bits(l_ffb), .sat(l_sat)
`ifdef ADDER_ERRMON_HIST_EN
    , .hist_sel(hist_sel), .hist_cnt(l_hist)
`endif
  );

  adder_error_monitor #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .valid(valid), .error(error),
    .bit_error(bit_error), .busy(s_busy), .done(s_done), .pass(s_pass),
    .sample_cnt(s_scnt), .fail_cnt(s_fcnt), .sticky_bits(s_sticky),
    .first_fail_vld(s_ffv), .first_fail_idx(s_ffi), .first_fail_bits(s_ffb), .sat(s_sat)
`ifdef ADDER_ERRMON_HIST_EN
    , .hist_sel(hist_sel), .hist_cnt(s_hist)
`endif
  );

  function automatic res_t main_res();
    return {m_pass, m_scnt, m_fcnt, m_sticky, m_ffv, m_ffi, m_ffb};
  endfunction

  function automatic res_t model_res(input logic is_done);
    return {is_done && (mdl_fail == 16'd0), mdl_cnt, mdl_fail, mdl_sticky, mdl_ffv, mdl_ffi, mdl_ffb};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    mdl_run = 1'b0;
  endtask

  task automatic begin_window();
    start = 1'b1;
    mdl_run = 1'b1;
    mdl_cnt = '0; mdl_fail = '0; mdl_sticky = '0; mdl_ffv = 1'b0; mdl_ffi = '0; mdl_ffb = '0;
    step();
    start = 1'b0;
  endtask

  task automatic send(input logic e, input logic [16:0] b);
    valid = 1'b1; error = e; bit_error = b;
    if (mdl_run) begin
      if (e && !mdl_ffv) begin
        mdl_ffv = 1'b1; mdl_ffi = mdl_cnt; mdl_ffb = b;
      end
      mdl_cnt = mdl_cnt + 16'd1;
      if (e) mdl_fail = mdl_fail + 16'd1;
      mdl_sticky = mdl_sticky | b;
    end
    step();
    valid = 1'b0; error = 1'b0; bit_error = '0;
  endtask

  task automatic end_window();
    stop = 1'b1;
    mdl_run = 1'b0;
    sb.push_back(model_res(1'b1));
    step();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if (main_res() !== '0 || {m_busy, m_done, m_sat} !== 3'b000) begin
      errors++;
      $display("FAIL reset_main got %h busy/done/sat %b expected 0", main_res(), {m_busy, m_done, m_sat});
    end
    checks++;
    if ({l_busy, l_done, s_busy, s_done, s_sat, s_fcnt} !== '0) begin
      errors++;
      $display("FAIL reset_variants got %b expected 0", {l_busy, l_done, s_busy, s_done, s_sat, s_fcnt});
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_clean_window();
    apply_reset();
    begin_window();
    checks++;
    if (m_busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_start got %b expected 1", m_busy);
    end
    for (int i = 0; i < 10; i++) send(1'b0, 17'h0);
    end_window();
    for (int i = 0; i < 20; i++) begin
      if (m_done) break;
      step();
    end
    exp_r = sb.pop_front();
    act_r = main_res();
    checks++;
    if (m_done !== 1'b1 || act_r !== exp_r) begin
      errors++;
      $display("FAIL clean_window done %b got %h expected %h", m_done, act_r, exp_r);
    end
  endtask

  task automatic test_first_fail();
    apply_reset();
    begin_window();
    for (int i = 0; i < 6; i++) begin
      if (i == 3) send(1'b1, 17'h00010);
      else if (i == 5) send(1'b1, 17'h10001);
      else send(1'b0, 17'h0);
    end
    end_window();
    for (int i = 0; i < 20; i++) begin
      if (m_done) break;
      step();
    end
    exp_r = sb.pop_front();
    act_r = main_res();
    checks++;
    if (m_done !== 1'b1 || act_r !== exp_r) begin
      errors++;
      $display("FAIL first_fail done %b got %h expected %h", m_done, act_r, exp_r);
    end
    checks++;
    if ({m_fcnt, m_ffi, m_ffb, m_sticky, m_pass} !== {16'd2, 16'd3, 17'h00010, 17'h10011, 1'b0}) begin
      errors++;
      $display("FAIL first_fail_fields fail %0d idx %0d bits %h sticky %h pass %b expected 2 3 00010 10011 0",
               m_fcnt, m_ffi, m_ffb, m_sticky, m_pass);
    end
  endtask

  task automatic test_done_behaviour();
    send(1'b1, 17'h1ffff);
    send(1'b1, 17'h00100);
    sb.push_back(model_res(1'b1));
    exp_r = sb.pop_front();
    act_r = main_res();
    checks++;
    if (m_done !== 1'b1 || act_r !== exp_r) begin
      errors++;
      $display("FAIL done_hold done %b got %h expected %h", m_done, act_r, exp_r);
    end
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    checks++;
    if ({m_busy, m_done, m_scnt, m_ffv, m_sticky} !== {1'b1, 1'b0, 16'd0, 1'b0, 17'h0}) begin
      errors++;
      $display("FAIL start_stop_in_done busy %b done %b cnt %0d ffv %b sticky %h expected 1 0 0 0 0",
               m_busy, m_done, m_scnt, m_ffv, m_sticky);
    end
  endtask

  task automatic test_stop_with_valid();
    apply_reset();
    begin_window();
    send(1'b0, 17'h0);
    send(1'b0, 17'h00002);
    stop = 1'b1;
    send(1'b1, 17'h00005);
    stop = 1'b0;
    mdl_run = 1'b0;
    sb.push_back(model_res(1'b1));
    exp_r = sb.pop_front();
    act_r = main_res();
    checks++;
    if (m_done !== 1'b1 || act_r !== exp_r) begin
      errors++;
      $display("FAIL stop_with_valid done %b got %h expected %h", m_done, act_r, exp_r);
    end
  endtask

  task automatic test_start_stop_in_run();
    apply_reset();
    begin_window();
    send(1'b0, 17'h0);
    start = 1'b1;
    end_window();
    start = 1'b0;
    exp_r = sb.pop_front();
    act_r = main_res();
    checks++;
    if ({m_done, m_busy} !== 2'b10 || act_r !== exp_r) begin
      errors++;
      $display("FAIL start_stop_in_run done/busy %b got %h expected %h", {m_done, m_busy}, act_r, exp_r);
    end
  endtask

  task automatic test_limit();
    apply_reset();
    begin_window();
    valid = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i == 3) begin
        checks++;
        if ({l_busy, l_done, l_scnt} !== {1'b1, 1'b0, 16'd3}) begin
          errors++;
          $display("FAIL limit_before busy %b done %b cnt %0d expected 1 0 3", l_busy, l_done, l_scnt);
        end
      end
      if (i == 4) begin
        checks++;
        if ({l_busy, l_done, l_scnt} !== {1'b0, 1'b1, 16'd4}) begin
          errors++;
          $display("FAIL limit_hit busy %b done %b cnt %0d expected 0 1 4", l_busy, l_done, l_scnt);
        end
      end
    end
    valid = 1'b0;
    checks++;
    if ({l_done, l_scnt, l_pass} !== {1'b1, 16'd4, 1'b1}) begin
      errors++;
      $display("FAIL limit_hold done %b cnt %0d pass %b expected 1 4 1", l_done, l_scnt, l_pass);
    end
  endtask

  task automatic test_saturation();
    apply_reset();
    begin_window();
    for (int i = 0; i < 20; i++) send(1'b1, 17'h0);
    end_window();
    checks++;
    if ({s_fcnt, s_scnt, s_sat, s_done} !== {4'd15, 4'd15, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL sat_counts fail %0d samples %0d sat %b done %b expected 15 15 1 1", s_fcnt, s_scnt, s_sat, s_done);
    end
    checks++;
    if ({m_sat, m_fcnt} !== {1'b0, 16'd20}) begin
      errors++;
      $display("FAIL sat_wide sat %b fail %0d expected 0 20", m_sat, m_fcnt);
    end
    begin_window();
    checks++;
    if ({s_fcnt, s_sat, s_busy} !== {4'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL sat_clear fail %0d sat %b busy %b expected 0 0 1", s_fcnt, s_sat, s_busy);
    end
  endtask

  task automatic test_reset_mid_window();
    apply_reset();
    begin_window();
    send(1'b1, 17'h00f00);
    send(1'b0, 17'h0);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (main_res() !== '0 || {m_busy, m_done, m_sat} !== 3'b000) begin
      errors++;
      $display("FAIL reset_async got %h busy/done/sat %b expected 0", main_res(), {m_busy, m_done, m_sat});
    end
    step();
    rst = 1'b0;
    valid = 1'b1;
    step();
    step();
    valid = 1'b0;
    checks++;
    if ({m_busy, m_done, m_scnt} !== {1'b0, 1'b0, 16'd0}) begin
      errors++;
      $display("FAIL no_resume busy %b done %b cnt %0d expected 0 0 0", m_busy, m_done, m_scnt);
    end
  endtask

`ifdef ADDER_ERRMON_HIST_EN
  task automatic test_histogram();
    apply_reset();
    begin_window();
    for (int i = 0; i < 3; i++) send(1'b0, 17'h10000);
    send(1'b1, 17'h00001);
    hist_sel = 5'd16;
    #1;
    checks++;
    if (m_hist !== 16'd3) begin
      errors++;
      $display("FAIL hist_bit16 got %0d expected 3", m_hist);
    end
    hist_sel = 5'd20;
    #1;
    checks++;
    if (m_hist !== 16'd0) begin
      errors++;
      $display("FAIL hist_out_of_range got %0d expected 0", m_hist);
    end
    hist_sel = 5'd0;
    #1;
    checks++;
    if (m_hist !== 16'd1) begin
      errors++;
      $display("FAIL hist_bit0 got %0d expected 1", m_hist);
    end
  endtask
`endif

  initial begin
    mdl_run = 1'b0;
    mdl_cnt = '0; mdl_fail = '0; mdl_sticky = '0; mdl_ffv = 1'b0; mdl_ffi = '0; mdl_ffb = '0;
    test_reset();
    test_clean_window();
    test_first_fail();
    test_done_behaviour();
    test_stop_with_valid();
    test_start_stop_in_run();
    test_limit();
    test_saturation();
    test_reset_mid_window();
`ifdef ADDER_ERRMON_HIST_EN
    test_histogram();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_error_monitor.md
ADDER_ERROR_MONITOR -- requirements
Module: adder_error_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 17, the compared-word width.
REQ-002 SHALL have parameter CNT_W, default 16, the counter width.
REQ-003 SHALL have parameter MAX_SAMPLES, default 0, the auto-stop sample limit; 0 means unlimited.
REQ-004 clk  input  1  clock; the single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-high.
REQ-006 start  input  1  begin a test window; clears statistics.
REQ-007 stop  input  1  end the test window.
REQ-008 valid  input  1  error/bit_error hold a comparator sample this cycle.
REQ-009 error  input  1  comparator mismatch flag.
REQ-010 bit_error  input  WIDTH  comparator per-bit XOR mismatch.
REQ-011 busy  output  1  window open (state RUN).
REQ-012 done  output  1  window closed with results held (state DONE).
REQ-013 pass  output  1  done and fail_cnt==0.
REQ-014 sample_cnt  output  CNT_W  valid samples accepted in the window.
REQ-015 fail_cnt  output  CNT_W  accepted samples with error=1.
REQ-016 sticky_bits  output  WIDTH  OR of bit_error over all accepted samples.
REQ-017 first_fail_vld  output  1  first-failure capture holds data.
REQ-018 first_fail_idx  output  CNT_W  sample_cnt value at the first failing sample.
REQ-019 first_fail_bits  output  WIDTH  bit_error of the first failing sample.
REQ-020 sat  output  1  a counter has saturated; sticky within the window.

Function
REQ-021 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-022 Transitions SHALL be: IDLE->RUN on start; RUN->DONE on stop or on reaching the limit (REQ-025); DONE->RUN on start; no other exits.
REQ-023 On entry to RUN, all statistics and capture outputs SHALL be cleared in the same edge that sets busy; busy SHALL be high the following cycle.
REQ-024 In RUN, each cycle with valid=1 SHALL accept the sample: sample_cnt+1; fail_cnt+1 if error=1; sticky_bits |= bit_error.
REQ-025 When MAX_SAMPLES!=0, the accept that makes sample_cnt==MAX_SAMPLES SHALL move the FSM to DONE on the same edge.
REQ-026 On the first accepted sample with error=1, the block SHALL load first_fail_idx (pre-increment sample_cnt) and first_fail_bits, and set first_fail_vld; later failures SHALL NOT overwrite the capture.
REQ-027 A sample with valid=1 in the same cycle as stop SHALL still be accepted.
REQ-028 start and stop in the same cycle: in RUN, stop SHALL win; in IDLE or DONE, start SHALL win.
REQ-029 Counters SHALL saturate at all-ones, and sat SHALL be set when any counter saturates.
REQ-030 valid in IDLE or DONE SHALL be ignored.
REQ-031 In DONE, all results SHALL hold; pass SHALL be combinational from state and fail_cnt.
REQ-032 error=0 with a nonzero bit_error SHALL still update sticky_bits; fail_cnt follows error only.

Reset
REQ-033 rst SHALL force state IDLE, clear every counter, sticky_bits, all capture outputs and sat, and drive busy, done and pass low, immediately (asynchronous).
REQ-034 rst asserted mid-window SHALL discard the window; there SHALL be no resume.

Configuration
REQ-035 Macro ADDER_ERRMON_HIST_EN SHALL compile in per-bit histogram ports: input hist_sel [$clog2(WIDTH)-1:0] and output hist_cnt [CNT_W-1:0].
REQ-036 With ADDER_ERRMON_HIST_EN defined, hist_cnt SHALL give the count of accepted samples with bit_error[hist_sel]=1; these counters are saturating, cleared on reset and on window start, and included in sat.
REQ-037 With ADDER_ERRMON_HIST_EN defined, hist_sel >= WIDTH SHALL read 0.
REQ-038 Without ADDER_ERRMON_HIST_EN, the histogram ports and counters SHALL be absent.

Structure
REQ-039 A shared package adder_test_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE) and the WIDTH/CNT_W default constants.
REQ-040 A single sub-module adder_sat_counter (clear, inc, saturating, sat flag) SHALL be instantiated for sample_cnt, fail_cnt and each histogram counter.

Verification
REQ-041 rst; start; 10 valid samples with error=0 and bit_error=0; stop -> done=1, pass=1, sample_cnt=10, fail_cnt=0, sticky_bits=0, first_fail_vld=0.
REQ-042 Samples 0..5 where sample 3 has bit_error=17'h00010, error=1 and sample 5 has bit_error=17'h10001, error=1 -> fail_cnt=2, first_fail_idx=3, first_fail_bits=17'h00010, sticky_bits=17'h10011, pass=0.
REQ-043 MAX_SAMPLES=4 with continuous valid -> DONE entered on the edge accepting the 4th sample; sample_cnt=4; further valid ignored.
REQ-044 CNT_W=4 with 20 failing samples -> fail_cnt=15 and sat=1; a new start clears both.
REQ-045 Same-cycle stop+valid(error=1) counted; stop+start in RUN -> DONE; rst asserted mid-window -> outputs zero asynchronously, state IDLE.
REQ-046 With ADDER_ERRMON_HIST_EN defined: 3 samples with bit_error[16]=1 -> hist_sel=16 gives hist_cnt=3; hist_sel=20 gives 0.
